// File: rtl/cplx_delay_line_if.sv
// Sample bus for the complex delay line: input sample, current/delayed outputs, status.
interface cplx_delay_line_if #(
    parameter int unsigned WIDTH = 24
);
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_r;
    logic [WIDTH-1:0] in_i;
    logic [WIDTH-1:0] cur_r;
    logic [WIDTH-1:0] cur_i;
    logic [WIDTH-1:0] dly_r;
    logic [WIDTH-1:0] dly_i;
    logic             out_valid;
    logic             primed;

    // Producer side: drives samples and control, observes outputs.
    modport master (
        output flush, in_valid, in_r, in_i,
        input  cur_r, cur_i, dly_r, dly_i, out_valid, primed
    );

    // Delay line side.
    modport slave (
        input  flush, in_valid, in_r, in_i,
        output cur_r, cur_i, dly_r, dly_i, out_valid, primed
    );
endinterface

// File: rtl/cplx_delay_line.sv
// Complex sample delay line: presents each accepted sample alongside the one accepted
// LAG samples earlier, optionally conjugating the delayed sample (with saturation).
module cplx_delay_line #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned LAG   = 16,
    parameter bit          CONJ  = 1'b0
) (
    input logic             clk,
    input logic             rst,
    cplx_delay_line_if.slave bus
);
    localparam int unsigned PtrW  = (LAG > 1) ? $clog2(LAG) : 1;
    localparam int unsigned FillW = $clog2(LAG + 1);

    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(LAG - 1);
    localparam logic [FillW-1:0] FillFull = FillW'(LAG);
    localparam logic [WIDTH-1:0] SMin     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMax     = {1'b0, {(WIDTH-1){1'b1}}};

    // History RAM, no reset: fill tracks which entries are meaningful.
    logic [WIDTH-1:0] buf_r [LAG];
    logic [WIDTH-1:0] buf_i [LAG];

    logic [PtrW-1:0]  wr_ptr;
    logic [FillW-1:0] fill;
    logic [WIDTH-1:0] cur_r, cur_i, dly_r, dly_i;
    logic             out_valid;

    logic             accept;
    logic [WIDTH-1:0] rd_r, rd_i, rd_i_out;

    // Accept decode and read-before-write of the oldest entry, with optional conjugate.
    always_comb begin
        accept   = bus.in_valid & ~bus.flush & ~rst;
        rd_r     = buf_r[wr_ptr];
        rd_i     = buf_i[wr_ptr];
        rd_i_out = rd_i;
        if (CONJ) begin
            // Negating the most negative value would overflow; clamp to the max.
            rd_i_out = (rd_i == SMin) ? SMax : -rd_i;
        end
    end

    // Write the accepted sample into the slot just read.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_r[wr_ptr] <= bus.in_r;
            buf_i[wr_ptr] <= bus.in_i;
        end
    end

    // Pointer, fill level and registered outputs; rst beats flush beats in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill      <= '0;
            cur_r     <= '0;
            cur_i     <= '0;
            dly_r     <= '0;
            dly_i     <= '0;
            out_valid <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            cur_r     <= bus.in_r;
            cur_i     <= bus.in_i;
            dly_r     <= rd_r;
            dly_i     <= rd_i_out;
            wr_ptr    <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
            fill      <= (fill == FillFull) ? fill : fill + 1'b1;
            out_valid <= (fill == FillFull);
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign bus.cur_r     = cur_r;
    assign bus.cur_i     = cur_i;
    assign bus.dly_r     = dly_r;
    assign bus.dly_i     = dly_i;
    assign bus.out_valid = out_valid;
    assign bus.primed    = (fill == FillFull);
endmodule

// File: doc/cplx_delay_line.md
CPLX_DELAY_LINE -- requirements
Module: cplx_delay_line

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24: bit width of each signed two's-complement real and imaginary component.
REQ-002 The block SHALL have parameter LAG, default 16, legal range LAG >= 2: delay in accepted samples between the current and delayed outputs.
REQ-003 The block SHALL have parameter CONJ, default 0: when 1, the delayed output is the complex conjugate.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port flush, input, 1 bit: discard history and restart priming.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_r/in_i carry a sample this cycle.
REQ-008 The block SHALL have ports in_r and in_i, inputs, WIDTH bits each: real and imaginary parts of the input sample.
REQ-009 The block SHALL have ports cur_r and cur_i, outputs, WIDTH bits each: registered copy of the last accepted sample.
REQ-010 The block SHALL have ports dly_r and dly_i, outputs, WIDTH bits each: the sample accepted LAG samples before cur.
REQ-011 The block SHALL have port out_valid, output, 1 bit: one-cycle strobe that cur/dly were updated with a real delayed sample.
REQ-012 The block SHALL have port primed, output, 1 bit: level, high when LAG samples of history are held.

Function
REQ-013 Storage SHALL be a LAG-entry circular buffer per component, with write pointer wr_ptr (0..LAG-1) and fill counter fill (0..LAG).
REQ-014 When in_valid=1 and flush=0, the block SHALL write the sample at wr_ptr and advance wr_ptr, wrapping from LAG-1 to 0.
REQ-015 In the same accepted cycle, the old buffer[wr_ptr] content SHALL be read (read-before-write) and registered to dly on the next edge; the input SHALL be registered to cur (latency 1 cycle).
REQ-016 Fill SHALL increment on each accepted sample and saturate at LAG; primed SHALL equal (fill == LAG).
REQ-017 out_valid SHALL be 1 in the cycle after an accepted sample only if fill == LAG before that write; otherwise it SHALL be 0.
REQ-018 During priming, cur SHALL still update on each accepted sample; dly content is don't-care while out_valid=0.
REQ-019 With in_valid=0, cur/dly SHALL hold, out_valid SHALL be 0, and wr_ptr/fill SHALL hold; lag SHALL be counted in accepted samples, not cycles.
REQ-020 flush=1 SHALL set wr_ptr=0 and fill=0, force out_valid=0 next cycle, and hold cur/dly; buffer contents need not clear.
REQ-021 When flush=1 and in_valid=1 occur together, flush SHALL win and the sample SHALL be discarded.
REQ-022 With CONJ=0, dly SHALL be the stored sample unchanged.
REQ-023 With CONJ=1, dly_r SHALL be unchanged and dly_i SHALL be the negated stored imaginary part.
REQ-024 With CONJ=1, a stored imaginary part of -2^(WIDTH-1) SHALL saturate to 2^(WIDTH-1)-1.

Reset
REQ-025 While rst=1, on the clock edge the block SHALL set cur_r, cur_i, dly_r, dly_i = 0, out_valid = 0, primed = 0, wr_ptr = 0 and fill = 0.
REQ-026 rst SHALL take priority over flush and in_valid.
REQ-027 Buffer RAM SHALL not require reset.
REQ-028 A reset asserted mid-stream SHALL discard all history; LAG new samples are then required before out_valid.

Verification (WIDTH=24, LAG=4 unless stated)
REQ-029 Priming: after reset, feed samples k=1..5 back-to-back as (k, -k). Required: out_valid=0 for k=1..4; primed=1 after k=4; after k=5, cur=(5,-5), dly=(1,-1), out_valid=1 for one cycle.
REQ-030 Gapped input: after priming, insert 3 idle cycles between samples. Required: outputs hold and out_valid=0 during the gaps; dly still equals sample k-4.
REQ-031 Wrap-around: feed 12 continuous samples. Required: for k=5..12, dly=(k-4, -(k-4)) and out_valid=1 every cycle.
REQ-032 Flush collision: after 8 samples, assert flush with in_valid=1 and sample 9. Required: sample 9 dropped, primed=0, next 4 samples give out_valid=0, and the 5th after flush gives dly equal to the 1st after flush.
REQ-033 Conjugate mode (CONJ=1): stored imaginary 0x800000 -> dly_i=0x7FFFFF; stored imaginary 5 -> dly_i=0xFFFFFB; dly_r unchanged.
REQ-034 Reset mid-operation: assert rst during streaming while primed=1. Required: next cycle all outputs 0 and primed=0; priming restarts per REQ-029.
